// File: rtl/vga_pkg.sv
// Shared phase encoding, default 640x480@60 timing and phase helpers for the raster generator.
package vga_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int phase_len(input phase_e ph, input int len_active, input int len_fp,
                                     input int len_sync, input int len_bp);
        case (ph)
            PH_ACTIVE: return len_active;
            PH_FP:     return len_fp;
            PH_SYNC:   return len_sync;
            default:   return len_bp;
        endcase
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_ACTIVE: return PH_FP;
            PH_FP:     return PH_SYNC;
            PH_SYNC:   return PH_BP;
            default:   return PH_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis.sv
// One raster axis: ACTIVE/FP/SYNC/BP phase FSM plus a position counter, both advanced by i_step.
// o_wrap flags the step that takes the position from its last value back to 0.
module vga_axis
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_step,
    output logic [W-1:0] o_pos,
    output phase_e       o_phase,
    output logic         o_wrap
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_phase
        $error("vga_axis: every phase length must be >= 1");
    end

    phase_e       r_phase;
    phase_e       w_phase_nxt;
    logic [W-1:0] r_sub;
    logic [W-1:0] w_sub_nxt;
    logic [W-1:0] r_pos;
    logic [W-1:0] w_pos_nxt;
    logic [W-1:0] w_len_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_ACTIVE;
            r_sub   <= '0;
            r_pos   <= '0;
        end else if (i_step) begin
            r_phase <= w_phase_nxt;
            r_sub   <= w_sub_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // Phase sub-count runs 0..len-1 independently of the position; both wrap together at TOTAL.
    always_comb begin
        w_len_m1    = W'(phase_len(r_phase, ACTIVE, FP, SYNC, BP) - 1);
        w_phase_nxt = r_phase;
        w_sub_nxt   = r_sub + 1'b1;
        if (r_sub == w_len_m1) begin
            w_sub_nxt   = '0;
            w_phase_nxt = next_phase(r_phase);
        end
        w_pos_nxt = (r_pos == W'(TOTAL - 1)) ? '0 : r_pos + 1'b1;
    end

    always_comb begin
        o_pos   = r_pos;
        o_phase = r_phase;
        o_wrap  = i_step && (r_pos == W'(TOTAL - 1));
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered hsync/vsync/active/x/y and line/frame strobes per pixel tick.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int FRAME_BITS = 16,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [FRAME_BITS-1:0] frame_count
`endif
);

    if (FRAME_BITS < 1) begin : g_bad_frame_bits
        $error("vga_timing_gen: FRAME_BITS must be >= 1");
    end

    logic [XW-1:0] w_hc;
    logic [YW-1:0] w_vc;
    phase_e        w_hph;
    phase_e        w_vph;
    logic          w_h_wrap;
    logic          w_v_wrap;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    vga_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (XW)
    ) u_h_axis (
        .clk     (clk),
        .rst     (reset),
        .i_step  (pix_en),
        .o_pos   (w_hc),
        .o_phase (w_hph),
        .o_wrap  (w_h_wrap)
    );

    // Vertical axis advances once per line, so vsync only changes across the line wrap.
    vga_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (YW)
    ) u_v_axis (
        .clk     (clk),
        .rst     (reset),
        .i_step  (w_h_wrap),
        .o_pos   (w_vc),
        .o_phase (w_vph),
        .o_wrap  (w_v_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_active      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_en) begin
                r_hsync       <= (w_hph == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                r_vsync       <= (w_vph == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
                r_active      <= (w_hph == PH_ACTIVE) && (w_vph == PH_ACTIVE);
                r_x           <= w_hc;
                r_y           <= w_vc;
                r_line_start  <= (w_hc == '0);
                r_frame_start <= (w_hc == '0) && (w_vc == '0);
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_BITS-1:0] r_frame_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (pix_en && (w_hc == '0) && (w_vc == '0)) begin
            r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 8x6 raster; the model derives position from the tick count.
module tb_vga_timing_gen;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = 8, VT = 6, FT = HT * VT;
  localparam int FB = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync, vsync, active, line_start, frame_start;
  logic [2:0] x;
  logic [2:0] y;
`ifdef VGA_FRAME_COUNT_EN
  logic [FB-1:0] frame_count;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_BITS(FB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ticks = 0;
  int cyc = 0;
  int m_fc = 0;
  bit m_ls = 1'b0;
  bit m_fs = 1'b0;
  int fs_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: ticks counts pixel ticks since reset; the presented pixel is ticks-1 in raster order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ticks = 0;
      m_ls  = 1'b0;
      m_fs  = 1'b0;
      m_fc  = 0;
    end else if (pix_en) begin
      ticks++;
      m_ls = (((ticks - 1) % FT) % HT) == 0;
      m_fs = ((ticks - 1) % FT) == 0;
      if (m_fs) m_fc++;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
  end

  always @(negedge clk) begin
    int p, ex, ey;
    bit ea, eh, ev;
    if (ticks == 0) begin
      ex = 0; ey = 0; ea = 1'b0; eh = 1'b1; ev = 1'b1;
    end else begin
      p  = (ticks - 1) % FT;
      ex = p % HT;
      ey = p / HT;
      ea = (ex < HA) && (ey < VA);
      eh = !((ex >= HA + HF) && (ex < HA + HF + HS));
      ev = !((ey >= VA + VF) && (ey < VA + VF + VS));
    end
    chk("x", 32'(x), 32'(ex));
    chk("y", 32'(y), 32'(ey));
    chk("active", 32'(active), 32'(ea));
    chk("hsync", 32'(hsync), 32'(eh));
    chk("vsync", 32'(vsync), 32'(ev));
    chk("line_start", 32'(line_start), 32'(m_ls));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count", 32'(frame_count), 32'(m_fc % (1 << FB)));
`endif
    if (frame_start === 1'b1) fs_q.push_back(cyc);
  end

  initial begin
    int cnt;
    bit found;

    // Reset held with pix_en high
    pix_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first_x", 32'(x), 32'd0);
    chk("first_y", 32'(y), 32'd0);
    chk("first_active", 32'(active), 32'd1);
    chk("first_line_start", 32'(line_start), 32'd1);
    chk("first_frame_start", 32'(frame_start), 32'd1);
    @(posedge clk); #1;
    chk("second_x", 32'(x), 32'd1);
    chk("second_frame_start", 32'(frame_start), 32'd0);

    // Continuous run: vsync low count across one frame and frame period
    fs_q.delete();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (frame_start) found = 1'b1;
    end
    chk("wait_frame_start", 32'(found), 32'd1);
    cnt = (vsync == 1'b0) ? 1 : 0;
    repeat (FT - 1) begin
      @(posedge clk); #1;
      if (vsync == 1'b0) cnt++;
    end
    chk("vsync_low_pixels", 32'(cnt), 32'd8);
    repeat (60) @(posedge clk);
    #1;
    chk("fs_count_cont", 32'(fs_q.size() >= 2), 32'd1);
    if (fs_q.size() >= 2) chk("frame_period_cont", 32'(fs_q[1] - fs_q[0]), 32'd48);

    // One tick in four
    fs_q.delete();
    for (int i = 0; i < 450; i++) begin
      pix_en = (i % 4 == 3);
      @(posedge clk); #1;
    end
    chk("fs_count_slow", 32'(fs_q.size() >= 2), 32'd1);
    if (fs_q.size() >= 2) chk("frame_period_slow", 32'(fs_q[1] - fs_q[0]), 32'd192);

    // Random pixel ticks
    for (int i = 0; i < 600; i++) begin
      pix_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end

    // Reset mid-line at (5,2), between clock edges
    pix_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (x == 3'd5 && y == 3'd2) found = 1'b1;
    end
    chk("reach_5_2", 32'(found), 32'd1);
    chk("pre_rst_hsync", 32'(hsync), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_x", 32'(x), 32'd0);
    chk("async_y", 32'(y), 32'd0);
    chk("async_hsync", 32'(hsync), 32'd1);
    chk("async_vsync", 32'(vsync), 32'd1);
    chk("async_active", 32'(active), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("restart_x", 32'(x), 32'd0);
    chk("restart_y", 32'(y), 32'd0);
    chk("restart_frame_start", 32'(frame_start), 32'd1);

`ifdef VGA_FRAME_COUNT_EN
    begin
      logic [FB-1:0] fc_q[$];
      logic [FB-1:0] fc_exp[5];
      fc_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      fc_q.push_back(frame_count);
      for (int i = 0; i < 5 * FT && fc_q.size() < 5; i++) begin
        @(posedge clk); #1;
        if (frame_start) fc_q.push_back(frame_count);
      end
      chk("fc_samples", 32'(fc_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < fc_q.size(); i++) chk("fc_seq", 32'(fc_q[i]), 32'(fc_exp[i]));
    end
`else
    repeat (250) @(posedge clk);
`endif

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
